// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, byte/half/word loads and stores
// over a req/ack data bus, with misalignment detection.
module mem_stage #(
  parameter int LOAD_FLUSH_X = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wreg_addr,
  input  logic        mem_wreg_enable,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wreg_addr,
  output logic        wb_wreg_enable,
  output logic [31:0] wb_wdata,
  output logic        stallreq_mem,
  output logic        excp_adel,
  output logic        excp_ades,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] load_buf;

  logic        is_load;
  logic        is_store;
  logic        sext;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic        misalign;
  logic        go;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        unused;

  assign unused = ^{stall[5], stall[3:0]};
  assign lane   = mem_mem_addr[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_B;
    unique case (1'b1)
      (mem_aluop == OP_LB): begin
        is_load = 1'b1;
        sext    = 1'b1;
      end
      (mem_aluop == OP_LBU): is_load = 1'b1;
      (mem_aluop == OP_LH): begin
        is_load = 1'b1;
        sext    = 1'b1;
        size    = SZ_H;
      end
      (mem_aluop == OP_LHU): begin
        is_load = 1'b1;
        size    = SZ_H;
      end
      (mem_aluop == OP_LW): begin
        is_load = 1'b1;
        size    = SZ_W;
      end
      (mem_aluop == OP_SB): is_store = 1'b1;
      (mem_aluop == OP_SH): begin
        is_store = 1'b1;
        size     = SZ_H;
      end
      (mem_aluop == OP_SW): begin
        is_store = 1'b1;
        size     = SZ_W;
      end
      default: ;
    endcase
  end

  assign misalign = ((size == SZ_H) && lane[0]) ||
                    ((size == SZ_W) && (lane != 2'b00));
  assign go        = (is_load || is_store) && !misalign;
  assign excp_adel = is_load && misalign;
  assign excp_ades = is_store && misalign;

  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = mem_reg2;
    unique case (size)
      SZ_B: begin
        sel_c   = 4'b0001 << lane;
        wdata_c = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        sel_c   = 4'b0011 << lane;
        wdata_c = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_sel   <= 4'b0000;
      dbus_addr  <= 32'h0;
      dbus_wdata <= 32'h0;
      load_buf   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          state      <= BUSY;
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_sel   <= sel_c;
          dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
          dbus_wdata <= wdata_c;
        end
        BUSY: if (dbus_ack) begin
          state    <= DONE;
          dbus_req <= 1'b0;
          load_buf <= dbus_rdata;
        end
        DONE: if (!stall[4]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ld_byte = load_buf[7:0];
    unique case (lane)
      2'd1: ld_byte = load_buf[15:8];
      2'd2: ld_byte = load_buf[23:16];
      2'd3: ld_byte = load_buf[31:24];
      default: ;
    endcase
    ld_half = lane[1] ? load_buf[31:16] : load_buf[15:0];
    unique case (size)
      SZ_B:    ld_ext = {{24{sext & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_ext = load_buf;
    endcase
  end

  assign stallreq_mem = (state == BUSY) || ((state == IDLE) && go);
  assign wb_wreg_addr = mem_wreg_addr;

  always_comb begin
    wb_wreg_enable = mem_wreg_enable;
    wb_wdata       = mem_wdata;
    if (is_load || is_store) begin
      wb_wreg_enable = 1'b0;
      if (go && is_load) begin
        if (state == DONE) begin
          wb_wreg_enable = mem_wreg_enable;
          wb_wdata       = ld_ext;
        end else begin
          wb_wdata = (LOAD_FLUSH_X != 0) ? 32'h0 : mem_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores,
// misalignment, downstream hold and asynchronous reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_wreg_addr;
  logic        mem_wreg_enable;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wreg_addr;
  logic        wb_wreg_enable;
  logic [31:0] wb_wdata;
  logic        stallreq_mem;
  logic        excp_adel;
  logic        excp_ades;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int req_cnt;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  mem_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .mem_wreg_addr(mem_wreg_addr),
    .mem_wreg_enable(mem_wreg_enable),
    .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2),
    .wb_wreg_addr(wb_wreg_addr),
    .wb_wreg_enable(wb_wreg_enable),
    .wb_wdata(wb_wdata),
    .stallreq_mem(stallreq_mem),
    .excp_adel(excp_adel),
    .excp_ades(excp_ades),
    .dbus_req(dbus_req),
    .dbus_we(dbus_we),
    .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an op at a falling edge and plays the bus slave, acking in
  // the ack_cyc-th cycle that dbus_req is high. Returns inside DONE.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] r2, input int ack_cyc,
                       input logic [31:0] rd);
    @(negedge clk);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = r2;
    stall_cnt    = 0;
    req_cnt      = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stallreq_mem) break;
      stall_cnt++;
      if (dbus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          cap_we    = dbus_we;
          cap_sel   = dbus_sel;
          cap_addr  = dbus_addr;
          cap_wdata = dbus_wdata;
        end
      end
      dbus_ack   = dbus_req && (req_cnt == ack_cyc);
      dbus_rdata = rd;
      @(negedge clk);
      dbus_ack = 1'b0;
    end
    chk("access_complete", {31'b0, stallreq_mem}, 32'h0);
  endtask

  task automatic to_nop();
    mem_aluop    = 8'h20;
    mem_mem_addr = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b0;
    stall           = 6'b0;
    mem_wreg_addr   = 5'd7;
    mem_wreg_enable = 1'b1;
    mem_wdata       = 32'h5555_5555;
    mem_aluop       = 8'h20;
    mem_mem_addr    = 32'h0;
    mem_reg2        = 32'h0;
    dbus_ack        = 1'b0;
    dbus_rdata      = 32'h0;
    #12;
    chk("rst_req", {31'b0, dbus_req}, 32'h0);
    chk("rst_we", {31'b0, dbus_we}, 32'h0);
    chk("rst_sel", {28'b0, dbus_sel}, 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq_mem}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU pass-through
    mem_wreg_addr = 5'd5;
    mem_wdata     = 32'h1234;
    #1;
    chk("pt_wdata", wb_wdata, 32'h1234);
    chk("pt_addr", {27'b0, wb_wreg_addr}, 32'd5);
    chk("pt_en", {31'b0, wb_wreg_enable}, 32'h1);
    chk("pt_stallreq", {31'b0, stallreq_mem}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("pt_noreq", {31'b0, dbus_req}, 32'h0);

    // LB, ack in second request cycle
    issue(8'hE0, 32'h1003, 32'h0, 2, 32'h80FF_0000);
    chk("lb_sel", {28'b0, cap_sel}, 32'h8);
    chk("lb_addr", cap_addr, 32'h1000);
    chk("lb_we", {31'b0, cap_we}, 32'h0);
    chk("lb_stallcyc", stall_cnt, 32'd3);
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_en", {31'b0, wb_wreg_enable}, 32'h1);
    chk("lb_reqdrop", {31'b0, dbus_req}, 32'h0);
    to_nop();

    issue(8'hE4, 32'h1003, 32'h0, 2, 32'h80FF_0000);
    chk("lbu_wdata", wb_wdata, 32'h0000_0080);
    to_nop();

    // LH upper half, sign-extended
    issue(8'hE1, 32'h6002, 32'h0, 1, 32'h8001_1234);
    chk("lh_sel", {28'b0, cap_sel}, 32'hC);
    chk("lh_wdata", wb_wdata, 32'hFFFF_8001);
    to_nop();

    // SH, ack on first request cycle
    issue(8'hE9, 32'h2002, 32'hAAAA_BEEF, 1, 32'h0);
    chk("sh_we", {31'b0, cap_we}, 32'h1);
    chk("sh_sel", {28'b0, cap_sel}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", cap_addr, 32'h2000);
    chk("sh_stallcyc", stall_cnt, 32'd2);
    chk("sh_en", {31'b0, wb_wreg_enable}, 32'h0);
    to_nop();

    // Misaligned LW / SW
    mem_aluop    = 8'hE3;
    mem_mem_addr = 32'h3001;
    #1;
    chk("lw_mis_adel", {31'b0, excp_adel}, 32'h1);
    chk("lw_mis_stall", {31'b0, stallreq_mem}, 32'h0);
    chk("lw_mis_en", {31'b0, wb_wreg_enable}, 32'h0);
    @(negedge clk);
    chk("lw_mis_noreq", {31'b0, dbus_req}, 32'h0);
    mem_aluop    = 8'hEB;
    mem_mem_addr = 32'h3002;
    #1;
    chk("sw_mis_ades", {31'b0, excp_ades}, 32'h1);
    chk("sw_mis_adel", {31'b0, excp_adel}, 32'h0);
    @(negedge clk);
    chk("sw_mis_noreq", {31'b0, dbus_req}, 32'h0);
    to_nop();

    // LW held in DONE by downstream stall
    issue(8'hE3, 32'h5000, 32'h0, 1, 32'hCAFE_F00D);
    stall = 6'b010000;
    chk("hold_d0", wb_wdata, 32'hCAFE_F00D);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("hold_wdata", wb_wdata, 32'hCAFE_F00D);
      chk("hold_stallreq", {31'b0, stallreq_mem}, 32'h0);
    end
    stall = 6'b0;
    @(negedge clk);
    #1;
    chk("hold_idle_stallreq", {31'b0, stallreq_mem}, 32'h1);
    chk("hold_idle_wdata", wb_wdata, 32'h0);
    mem_aluop = 8'h20;
    @(negedge clk);

    // Asynchronous reset while BUSY
    mem_aluop    = 8'hE3;
    mem_mem_addr = 32'h4000;
    @(negedge clk);
    #1;
    chk("rb_req_up", {31'b0, dbus_req}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rb_req_drop", {31'b0, dbus_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rb_req_fresh", {31'b0, dbus_req}, 32'h1);
    chk("rb_addr", dbus_addr, 32'h4000);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h0;
    @(negedge clk);
    dbus_ack = 1'b0;
    to_nop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Passes ALU results through unchanged. Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus and sign/zero-extends load data.
- Raises a stall request to the pipeline stall controller while a bus access is outstanding.
- Flags misaligned halfword/word accesses instead of performing them.

Parameters:
- LOAD_FLUSH_X, 1, when 1, drive 32'hxxxxxxxx-free zero on wb_wdata while a load is incomplete (only value 1 is supported).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  stall vector from the stall controller; bit 4 = MEM stage held.
- mem_wreg_addr  in  5  destination register from EX/MEM.
- mem_wreg_enable  in  1  write enable from EX/MEM.
- mem_wdata  in  32  ALU result from EX/MEM.
- mem_aluop  in  8  operation code from EX/MEM.
- mem_mem_addr  in  32  effective byte address.
- mem_reg2  in  32  store data (rt).
- wb_wreg_addr  out  5  to MEM/WB.
- wb_wreg_enable  out  1  to MEM/WB.
- wb_wdata  out  32  to MEM/WB.
- stallreq_mem  out  1  stall request to the controller.
- excp_adel  out  1  misaligned load.
- excp_ades  out  1  misaligned store.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write enable.
- dbus_sel  out  4  byte lanes.
- dbus_addr  out  32  word-aligned address.
- dbus_wdata  out  32  write data.
- dbus_ack  in  1  one-cycle completion pulse.
- dbus_rdata  in  32  read data, valid with ack.

Behaviour:
- Opcodes:
  - LB=8'hE0, LBU=8'hE4, LH=8'hE1, LHU=8'hE5, LW=8'hE3.
  - SB=8'hE8, SH=8'hE9, SW=8'hEB.
  - Any other code is a non-memory op.
- Misalignment:
  - LH/LHU/SH misaligned when addr[0]=1. LW/SW misaligned when addr[1:0]!=0.
  - A misaligned op makes no bus access and asserts excp_adel (load) or excp_ades (store) combinationally.
  - wb_wreg_enable=0 and stallreq_mem=0 for a misaligned op.
- Non-memory op: wb_* = mem_* combinationally, zero latency, stallreq_mem=0.
- Little-endian byte lanes (o = addr[1:0]):
  - Byte access: sel = 4'b0001<<o.
  - Half access: sel = 4'b0011<<o.
  - Word access: sel = 4'b1111.
  - dbus_addr = {addr[31:2],2'b00}.
  - dbus_wdata: SB = {4{reg2[7:0]}}; SH = {2{reg2[15:0]}}; SW = reg2.
- Load extract: select the byte/half at lane o from the captured word. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned mem op present: stallreq_mem=1. Next edge goes to BUSY, registering dbus_req=1 and dbus_we/sel/addr/wdata.
  - BUSY: dbus_req held high with stable outputs; stallreq_mem=1. On the edge where dbus_ack=1, capture dbus_rdata into load_buf, drop dbus_req, go to DONE.
  - DONE: stallreq_mem=0.
    - Loads: wb_wdata = extracted load_buf, wb_wreg_enable = mem_wreg_enable.
    - Stores: wb_wreg_enable=0.
    - DONE -> IDLE on the edge where stall[4]=0; stay in DONE while stall[4]=1.
- While in IDLE/BUSY with a load: wb_wreg_enable=0, wb_wdata=0.
- Minimum access latency is 3 cycles: op visible in cycle 0, req in cycle 1, ack earliest in cycle 1, result in cycle 2.
- Bus protocol:
  - dbus_ack outside BUSY is ignored.
  - dbus_req never deasserts before ack.
  - Only one outstanding access.
- Reset (rst=0, any time, including mid-BUSY), asynchronous:
  - State goes to IDLE.
  - dbus_req=0, dbus_we=0, dbus_sel=0, dbus_addr=0, dbus_wdata=0, load_buf=0.
  - Combinational outputs follow from IDLE.
  - An in-flight access is abandoned; the bus slave must tolerate a dropped req.

Test Plan:
- Pass-through: ADD op (8'h20), wdata=32'h1234, reg 5, enable=1 -> same cycle wb_wdata=32'h1234, wb_wreg_addr=5, stallreq_mem=0, dbus_req never asserts.
- LB: addr=32'h1003, slave acks 2 cycles after req with rdata=32'h80FF_0000 -> sel=4'b1000, dbus_addr=32'h1000, stallreq_mem high 3 cycles, then wb_wdata=32'hFFFF_FF80. Repeat with LBU -> wb_wdata=32'h0000_0080.
- SH: addr=32'h2002, reg2=32'hAAAA_BEEF, ack on first req cycle -> dbus_we=1, sel=4'b1100, dbus_wdata=32'hBEEF_BEEF, wb_wreg_enable=0, DONE reached 2 cycles after op.
- Misaligned: LW at 32'h3001 -> excp_adel=1, no dbus_req, stallreq_mem=0. SW at 32'h3002 -> excp_ades=1.
- Downstream hold: LW completes with rdata=32'hCAFE_F00D, then stall[4]=1 for 3 cycles -> remains in DONE with wb_wdata stable at 32'hCAFE_F00D, and returns to IDLE the cycle after stall[4]=0.
- Reset mid-BUSY: assert rst=0 asynchronously while dbus_req=1 -> dbus_req drops without a clock edge. After release with the same LW op present, a fresh req is issued.
